// File: rtl/register_file.sv
// MIPS 32x32 register file, two registered read ports, one write port, r0 hardwired to zero.
// Optional macro REGFILE_BYPASS_EN selects write-first reads on a same-edge index collision.
module register_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic              reg_write,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DATA_W-1:0] read_data1_q, read_data1_d;
  logic [DATA_W-1:0] read_data2_q, read_data2_d;
  logic              write_hit_s;

  assign write_hit_s = reg_write && (write_reg != {ADDR_W{1'b0}});

  // Next-state for the array and both operand latches.
  always_comb begin
    regs_d       = regs_q;
    read_data1_d = {DATA_W{1'b0}};
    read_data2_d = {DATA_W{1'b0}};
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_d[i] = {DATA_W{1'b0}};
      end
    end else begin
      if (write_hit_s) begin
        regs_d[write_reg] = write_data;
      end else begin
        regs_d = regs_q;
      end

      if (read_reg1 == {ADDR_W{1'b0}}) begin
        read_data1_d = {DATA_W{1'b0}};
`ifdef REGFILE_BYPASS_EN
      end else if (write_hit_s && (read_reg1 == write_reg)) begin
        read_data1_d = write_data;
`endif
      end else begin
        read_data1_d = regs_q[read_reg1];
      end

      if (read_reg2 == {ADDR_W{1'b0}}) begin
        read_data2_d = {DATA_W{1'b0}};
`ifdef REGFILE_BYPASS_EN
      end else if (write_hit_s && (read_reg2 == write_reg)) begin
        read_data2_d = write_data;
`endif
      end else begin
        read_data2_d = regs_q[read_reg2];
      end
    end
    // r0 storage is pinned so it can never hold anything but zero.
    regs_d[0] = {DATA_W{1'b0}};
  end

  // State registers; reset is folded into the _d logic above.
  always_ff @(posedge clk) begin
    regs_q       <= regs_d;
    read_data1_q <= read_data1_d;
    read_data2_q <= read_data2_d;
  end

  assign read_data1 = read_data1_q;
  assign read_data2 = read_data2_q;

endmodule

// File: tb/tb_register_file.sv
// Randomized self-checking bench for register_file against an array-based reference model.
module tb_register_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  read_reg1, read_reg2, write_reg;
  logic [31:0] write_data;
  logic        reg_write;
  logic [31:0] read_data1, read_data2;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [31:0] mem [32];

  register_file dut (
    .clk        (clk),
    .rst        (rst),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .write_reg  (write_reg),
    .write_data (write_data),
    .reg_write  (reg_write),
    .read_data1 (read_data1),
    .read_data2 (read_data2)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] model_read(input logic r, input logic [4:0] idx,
                                             input logic we, input logic [4:0] wa,
                                             input logic [31:0] wd);
    if (r || idx == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (we && wa != 5'd0 && wa == idx) return wd;
`endif
    return mem[idx];
  endfunction

  // One clock: drive on the falling edge, update model at the rising edge, check 1 time unit later.
  task automatic cycle(input logic r, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [4:0] wa, input logic [31:0] wd, input logic we);
    logic [31:0] e1, e2;
    @(negedge clk);
    rst = r; read_reg1 = a1; read_reg2 = a2;
    write_reg = wa; write_data = wd; reg_write = we;
    e1 = model_read(r, a1, we, wa, wd);
    e2 = model_read(r, a2, we, wa, wd);
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    end else if (we && wa != 5'd0) begin
      mem[wa] = wd;
    end
    #1;
    check_val("rd1", read_data1, e1);
    check_val("rd2", read_data2, e2);
  endtask

  task automatic wr(input logic [4:0] wa, input logic [31:0] wd);
    cycle(1'b0, 5'd0, 5'd0, wa, wd, 1'b1);
  endtask

  task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
    cycle(1'b0, a1, a2, 5'd0, 32'h0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    rst = 1'b1; read_reg1 = 5'd0; read_reg2 = 5'd0;
    write_reg = 5'd0; write_data = 32'h0; reg_write = 1'b0;

    // Reset and zero register
    cycle(1'b1, 5'd0, 5'd31, 5'd0, 32'h0, 1'b0);
    cycle(1'b1, 5'd0, 5'd31, 5'd0, 32'h0, 1'b0);
    check_val("reset_rd1", read_data1, 32'h0);
    check_val("reset_rd2", read_data2, 32'h0);
    rd(5'd0, 5'd31);
    check_val("r0_r31_a", read_data1, 32'h0);
    check_val("r0_r31_b", read_data2, 32'h0);
    wr(5'd0, 32'hDEADBEEF);
    rd(5'd0, 5'd0);
    check_val("r0_write_drop", read_data1, 32'h0);

    // Basic write/read
    wr(5'd5, 32'h12345678);
    wr(5'd31, 32'hCAFEF00D);
    rd(5'd5, 5'd31);
    check_val("basic_r5", read_data1, 32'h12345678);
    check_val("basic_r31", read_data2, 32'hCAFEF00D);

    // Write enable low
    wr(5'd7, 32'h00000011);
    cycle(1'b0, 5'd0, 5'd0, 5'd7, 32'hFFFFFFFF, 1'b0);
    rd(5'd7, 5'd7);
    check_val("we_low", read_data1, 32'h00000011);

    // Same-edge collision
    wr(5'd9, 32'hAAAA0000);
    cycle(1'b0, 5'd9, 5'd9, 5'd9, 32'h0000BBBB, 1'b1);
`ifdef REGFILE_BYPASS_EN
    check_val("coll_rd1", read_data1, 32'h0000BBBB);
    check_val("coll_rd2", read_data2, 32'h0000BBBB);
`else
    check_val("coll_rd1", read_data1, 32'hAAAA0000);
    check_val("coll_rd2", read_data2, 32'hAAAA0000);
`endif
    rd(5'd9, 5'd9);
    check_val("coll_next", read_data1, 32'h0000BBBB);

    // Reset mid-operation discards the concurrent write
    wr(5'd3, 32'h55555555);
    cycle(1'b1, 5'd3, 5'd4, 5'd4, 32'h77777777, 1'b1);
    rd(5'd3, 5'd4);
    check_val("mid_rst_r3", read_data1, 32'h0);
    check_val("mid_rst_r4", read_data2, 32'h0);

    // Sweep
    for (int i = 1; i < 32; i++) wr(5'(i), 32'(i) * 32'h01010101);
    for (int i = 0; i < 32; i += 2) begin
      rd(5'(i), 5'(i + 1));
      check_val("sweep_a", read_data1, 32'(i) * 32'h01010101);
      check_val("sweep_b", read_data2, 32'(i + 1) * 32'h01010101);
    end

    // Random traffic with frequent index collisions
    for (int n = 0; n < 400; n++) begin
      logic [4:0] a1, a2, wa;
      a1 = 5'($urandom_range(0, 31));
      a2 = 5'($urandom_range(0, 31));
      wa = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 31));
      cycle(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0, a1, a2, wa,
            $urandom, ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/register_file.md
# register_file

MIPS general-purpose register file with 32 × 32-bit registers, two read ports and one write port. It sits directly downstream of the 5-bit destination-register multiplexer, which supplies `write_reg`. Both read outputs are registered: they behave as the A/B operand latches of the multicycle datapath. Register 0 is hardwired to zero.

## Interface
Parameters:
- `DATA_W`, 32, register and data width
- `ADDR_W`, 5, register index width; depth is 2**`ADDR_W` (32)

Ports:
- `clk`  input  1  sole clock; all state updates on the rising edge
- `rst`  input  1  synchronous, active-high reset; sampled on the rising edge of `clk`
- `read_reg1`  input  `ADDR_W`  index for read port 1 (rs)
- `read_reg2`  input  `ADDR_W`  index for read port 2 (rt)
- `write_reg`  input  `ADDR_W`  destination index, from the 5-bit destination mux
- `write_data`  input  `DATA_W`  value to write
- `reg_write`  input  1  write enable
- `read_data1`  output  `DATA_W`  registered contents of `read_reg1`
- `read_data2`  output  `DATA_W`  registered contents of `read_reg2`

## Operation
- Storage: array `regs[0..31]`. `regs[0]` reads as 0 at all times and is never written.
- Write: on a rising edge with `reg_write`=1, `rst`=0 and `write_reg`≠0, `regs[write_reg]` ← `write_data`.
  - A write to index 0 is silently dropped.
  - `reg_write`=0 leaves the array unchanged regardless of the other write inputs.
- Read: on every rising edge with `rst`=0:
  - `read_data1` ← value of `regs[read_reg1]`
  - `read_data2` ← value of `regs[read_reg2]`
  - Reads have no enable; the outputs update every cycle.
- Index 0 read: the output register loads 0.
- Both ports may address the same register; each gets the same value.
- Reset (`rst`=1 at a rising edge):
  - all `regs[1..31]` ← 0
  - `read_data1` ← 0 and `read_data2` ← 0
  - any write presented in the same cycle is discarded
  - if `rst` is asserted in the middle of a sequence, only the state committed before that edge is lost; the next edge with `rst`=0 operates normally.
- No arithmetic is performed. All widths match exactly and no truncation or extension occurs.

## Timing
- Read latency: 1 cycle.
  - Index presented at edge N appears on `read_data*` after edge N.
  - The output holds until edge N+1.
- Write latency: the value is in the array after the write edge.
  - A read of that index at the next edge returns the new value.
- Same-edge write and read of the same non-zero index:
  - behaviour is governed by the Configuration section.
- Outputs change only on `clk` rising edges. There is no combinational path from inputs to outputs.
- Reset value of every output: 0.

## Configuration
- Macro: `REGFILE_BYPASS_EN`.
- Defined (write-first):
  - When `reg_write`=1, `write_reg`≠0 and `read_regX`==`write_reg` at the same edge, `read_dataX` loads `write_data`.
  - Index 0 is never bypassed and still loads 0.
  - Reset overrides the bypass.
- Undefined (read-first):
  - In the same situation, `read_dataX` loads the old array contents.
  - The new value is visible from the next read edge.
- The array write behaviour is identical in both builds.

## Test plan
- Reset and zero register:
  - Stimulus: hold `rst`=1 for 2 cycles, then read indices 0 and 31.
  - Required: both outputs are 0x00000000.
  - Stimulus: write 0xDEADBEEF to index 0, then read index 0.
  - Required: 0x00000000.
- Basic write/read:
  - Stimulus: write 0x12345678 to index 5 and 0xCAFEF00D to index 31, then read (5, 31).
  - Required: `read_data1`=0x12345678 and `read_data2`=0xCAFEF00D one cycle after the read indices are presented.
- Write-enable low:
  - Stimulus: with index 7 = 0x00000011, present `write_data`=0xFFFFFFFF, `write_reg`=7, `reg_write`=0, then read index 7.
  - Required: 0x00000011.
- Same-edge collision:
  - Setup: index 9 = 0xAAAA0000.
  - Stimulus: at one edge, write 0x0000BBBB to index 9 while reading index 9 on both ports.
  - Required with `REGFILE_BYPASS_EN`: both outputs = 0x0000BBBB.
  - Required without it: both outputs = 0xAAAA0000, then 0x0000BBBB after the next edge.
- Reset mid-operation:
  - Setup: index 3 = 0x55555555.
  - Stimulus: assert `rst` at the same edge as a write of 0x77777777 to index 4, deassert, then read (3, 4).
  - Required: both outputs = 0.
- Sweep:
  - Stimulus: write value `i`×0x01010101 to every index `i` = 1..31, then read all indices pairwise.
  - Required: every value matches; index 0 reads 0.
